// File: rtl/genie_mem_ctrl.sv
`timescale 1ns/1ps
// genie_mem_ctrl: single-request-in-flight controller between the accelerator
// read/write request channels and a single-port synchronous SRAM.
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   wvalid/waddr/wdata       write request (held until wready)
//   wready                   one-cycle write acknowledge
//   rvalid/raddr             read request (held until rready)
//   rready/rdata             one-cycle read strobe and read data
//   mem_ce/mem_we/mem_addr/mem_wdata/mem_rdata  SRAM port
//   err                      sticky out-of-range flag
//   busy                     high whenever the controller is not idle
module genie_mem_ctrl #(
  parameter int unsigned AW        = 26,
  parameter int unsigned DW        = 32,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned MEM_WORDS = 1 << 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wvalid,
  output logic          wready,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rvalid,
  output logic          rready,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          err,
  output logic          busy
);

  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_ISSUE, S_RD_WAIT, S_RD_ACK, S_OOR
  } state_e;

  typedef enum logic {G_READ, G_WRITE} grant_e;

  state_e          state_q, state_d;
  grant_e          last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wready_q, wready_d;
  logic            rready_q, rready_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            mem_ce_q, mem_ce_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic            raddr_oor_c;
  logic            waddr_oor_c;

  // Range check done at 64 bits so MEM_WORDS >= 2**AW is handled.
  assign raddr_oor_c = (64'(raddr) >= 64'(MEM_WORDS));
  assign waddr_oor_c = (64'(waddr) >= 64'(MEM_WORDS));

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= G_WRITE;
      cnt_q        <= '0;
      wready_q     <= 1'b0;
      rready_q     <= 1'b0;
      rdata_q      <= '0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      wready_q     <= wready_d;
      rready_q     <= rready_d;
      rdata_q      <= rdata_d;
      mem_ce_q     <= mem_ce_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  // Next state; outputs are computed for the state being entered so they
  // appear registered in that state's cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    wready_d     = 1'b0;
    rready_d     = 1'b0;
    rdata_d      = rdata_q;
    mem_ce_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        // Read wins when alone or when the write channel had the last grant.
        if (rvalid && (!wvalid || last_grant_q == G_WRITE)) begin
          last_grant_d = G_READ;
          if (raddr_oor_c) begin
            state_d  = S_OOR;
            err_d    = 1'b1;
            rready_d = 1'b1;
            rdata_d  = '0;
          end else begin
            state_d    = S_RD_ISSUE;
            mem_ce_d   = 1'b1;
            mem_addr_d = raddr;
          end
        end else if (wvalid) begin
          last_grant_d = G_WRITE;
          if (waddr_oor_c) begin
            state_d  = S_OOR;
            err_d    = 1'b1;
            wready_d = 1'b1;
          end else begin
            state_d     = S_WR;
            mem_ce_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = waddr;
            mem_wdata_d = wdata;
            wready_d    = 1'b1;
          end
        end
      end
      S_WR:       state_d = S_IDLE;
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
        cnt_d   = CW'(RD_LAT - 1);
      end
      S_RD_WAIT: begin
        // Last wait cycle: SRAM data is valid now, capture it for the ack.
        if (cnt_q == '0) begin
          state_d  = S_RD_ACK;
          rready_d = 1'b1;
          rdata_d  = mem_rdata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RD_ACK:   state_d = S_IDLE;
      S_OOR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign wready    = wready_q;
  assign rready    = rready_q;
  assign rdata     = rdata_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_genie_mem_ctrl.sv
`timescale 1ns/1ps
// Bench for genie_mem_ctrl: main instance (RD_LAT=2, 1024 words) plus two
// read-latency sweep instances (RD_LAT=1 and 7), each with its own SRAM model.
module tb_genie_mem_ctrl;

  localparam int unsigned AW    = 26;
  localparam int unsigned DW    = 32;
  localparam int unsigned LAT   = 2;
  localparam int unsigned WORDS = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wvalid, wready, rvalid, rready;
  logic [AW-1:0] waddr, raddr, mem_addr;
  logic [DW-1:0] wdata, rdata, mem_wdata, mem_rdata;
  logic          mem_ce, mem_we, err, busy;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  genie_mem_ctrl #(.AW(AW), .DW(DW), .RD_LAT(LAT), .MEM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .wvalid(wvalid), .wready(wready), .waddr(waddr), .wdata(wdata),
    .rvalid(rvalid), .rready(rready), .raddr(raddr), .rdata(rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .err(err), .busy(busy)
  );

  // SRAM environment model: unwritten words read back as addr*3.
  logic [DW-1:0] sram [int];
  logic [DW-1:0] rd_pipe [LAT];
  logic          rd_vld  [LAT];
  int            wr_log_a [$];
  logic [DW-1:0] wr_log_d [$];
  int            ce_count = 0;

  always @(posedge clk) begin
    int a;
    a = int'(mem_addr);
    if (mem_ce) ce_count++;
    if (mem_ce && mem_we) begin
      sram[a] = mem_wdata;
      wr_log_a.push_back(a);
      wr_log_d.push_back(mem_wdata);
    end
    for (int i = LAT - 1; i > 0; i--) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rd_vld[i]  <= rd_vld[i-1];
    end
    rd_pipe[0] <= sram.exists(a) ? sram[a] : DW'(a * 3);
    rd_vld[0]  <= mem_ce && !mem_we;
  end
  assign mem_rdata = rd_vld[LAT-1] ? rd_pipe[LAT-1] : 32'hBADC0FFE;

  // Reference memory contents, updated by the bench on each acknowledged write.
  logic [DW-1:0] ref_mem [int];
  function automatic logic [DW-1:0] ref_word(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : DW'(a * 3);
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    int k;
    bit oor;
    oor = 32'(a) >= WORDS;
    waddr = a; wdata = d; wvalid = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wready) break;
    end
    check({tag, "_lat"}, 64'(k), 64'd1);
    if (oor) begin
      check({tag, "_oor_ce"}, 64'(mem_ce), 64'd0);
      check({tag, "_oor_err"}, 64'(err), 64'd1);
    end else begin
      check({tag, "_ce_we"}, 64'({mem_ce, mem_we}), 64'd3);
      check({tag, "_addr"}, 64'(mem_addr), 64'(a));
      check({tag, "_wdata"}, 64'(mem_wdata), 64'(d));
      ref_mem[int'(a)] = d;
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input string tag);
    int k;
    bit oor;
    logic [DW-1:0] exp;
    oor = 32'(a) >= WORDS;
    exp = oor ? '0 : ref_word(int'(a));
    raddr = a; rvalid = 1'b1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rready) break;
    end
    check({tag, "_lat"}, 64'(k), oor ? 64'd1 : 64'(LAT + 2));
    check({tag, "_rdata"}, 64'(rdata), 64'(exp));
    if (oor) check({tag, "_err"}, 64'(err), 64'd1);
    @(posedge clk); #1;
    rvalid = 1'b0;
  endtask

  // Latency sweep instances: back-to-back reads of 0..15.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int unsigned SL = (g == 0) ? 1 : 7;
    logic          s_rst, s_rvalid, s_rready, s_wready, s_ce, s_we, s_err, s_busy;
    logic [AW-1:0] s_raddr, s_maddr;
    logic [DW-1:0] s_rdata, s_mwdata, s_mrdata;
    logic [DW-1:0] s_pipe [SL];
    logic          s_vld  [SL];
    bit            done = 1'b0;

    genie_mem_ctrl #(.AW(AW), .DW(DW), .RD_LAT(SL)) u_dut (
      .clk(clk), .rst(s_rst),
      .wvalid(1'b0), .wready(s_wready), .waddr('0), .wdata('0),
      .rvalid(s_rvalid), .rready(s_rready), .raddr(s_raddr), .rdata(s_rdata),
      .mem_ce(s_ce), .mem_we(s_we), .mem_addr(s_maddr),
      .mem_wdata(s_mwdata), .mem_rdata(s_mrdata),
      .err(s_err), .busy(s_busy)
    );

    always @(posedge clk) begin
      for (int i = SL - 1; i > 0; i--) begin
        s_pipe[i] <= s_pipe[i-1];
        s_vld[i]  <= s_vld[i-1];
      end
      s_pipe[0] <= DW'(s_maddr) * 3;
      s_vld[0]  <= s_ce && !s_we;
    end
    assign s_mrdata = s_vld[SL-1] ? s_pipe[SL-1] : 32'hBADC0FFE;

    initial begin
      int n, k, last;
      bit seen, busy_seen;
      s_rst = 1'b1; s_rvalid = 1'b0; s_raddr = '0;
      n = 0; k = 0; last = 0; busy_seen = 1'b0;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      @(posedge clk); #1;
      s_rvalid = 1'b1;
      while (n < 16 && k < 400) begin
        @(negedge clk);
        seen = s_rready;
        if (s_busy) busy_seen = 1'b1;
        if (seen) begin
          check($sformatf("sweep%0d_rdata%0d", SL, n), 64'(s_rdata), 64'(n * 3));
          if (n > 0) check($sformatf("sweep%0d_period%0d", SL, n), 64'(k - last), 64'(SL + 3));
          last = k;
        end
        k++;
        @(posedge clk); #1;
        if (seen) begin
          n++;
          if (n == 16) s_rvalid = 1'b0;
          else s_raddr = AW'(n);
        end
      end
      check($sformatf("sweep%0d_count", SL), 64'(n), 64'd16);
      check($sformatf("sweep%0d_quiet", SL), 64'({s_wready, s_err, busy_seen}), 64'd1);
      check($sformatf("sweep%0d_mwdata", SL), 64'(s_mwdata), 64'd0);
      done = 1'b1;
    end
  end

  initial begin
    int ce_before, nr, nw, both, idx, n, k, busy_err, rr_cnt;
    logic [7:0] ord_obs, ord_exp;
    bit ra, wa;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] b2b_d [8];

    rst = 1'b1; wvalid = 1'b0; rvalid = 1'b0;
    waddr = '0; wdata = '0; raddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 64'({rready, wready, mem_ce, mem_we, err, busy}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_maddr", 64'(mem_addr), 64'd0);
    check("rst_mwdata", 64'(mem_wdata), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single write then read-back.
    do_write(26'h10, 32'hDEADBEEF, "wr1");
    do_read(26'h10, "rd1");

    // Randomized write/read pairs plus a random read.
    for (int i = 0; i < 6; i++) begin
      a = AW'($urandom_range(0, WORDS - 1));
      d = $urandom;
      do_write(a, d, $sformatf("rwr%0d", i));
      do_read(a, $sformatf("rrd%0d", i));
      do_read(AW'($urandom_range(0, WORDS - 1)), $sformatf("rrx%0d", i));
    end

    // Contention from reset: reads of 200+i, writes of 201+i.
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    rvalid = 1'b1; raddr = AW'(200);
    wvalid = 1'b1; waddr = AW'(201); wdata = $urandom;
    nr = 0; nw = 0; both = 0; idx = 0; ord_obs = '0;
    for (int c = 0; c < 200 && (nr < 4 || nw < 4); c++) begin
      @(negedge clk);
      ra = rready; wa = wready;
      if (ra && wa) both++;
      if (ra) begin
        check($sformatf("cont_rdata%0d", nr), 64'(rdata), 64'(ref_word(int'(raddr))));
        if (idx < 8) ord_obs[3'(idx)] = 1'b1;
        idx++;
      end
      if (wa) begin
        ref_mem[int'(waddr)] = wdata;
        if (idx < 8) ord_obs[3'(idx)] = 1'b0;
        idx++;
      end
      @(posedge clk); #1;
      if (ra) begin
        nr++;
        if (nr == 4) rvalid = 1'b0; else raddr = AW'(200 + nr);
      end
      if (wa) begin
        nw++;
        if (nw == 4) wvalid = 1'b0;
        else begin waddr = AW'(201 + nw); wdata = $urandom; end
      end
    end
    for (int i = 0; i < 8; i++) ord_exp[i] = (i % 2 == 0);
    check("cont_order", 64'(ord_obs), 64'(ord_exp));
    check("cont_counts", 64'({idx[7:0], nr[7:0], nw[7:0]}), 64'({8'd8, 8'd4, 8'd4}));
    check("cont_overlap", 64'(both), 64'd0);

    // Out-of-range accesses never touch the SRAM; err is sticky.
    ce_before = ce_count;
    do_read(26'h400, "oor_rd");
    do_write(26'h3FFFFFF, $urandom, "oor_wr");
    check("oor_no_ce", 64'(ce_count), 64'(ce_before));
    do_write(26'h20, 32'h1234_5678, "post_oor_wr");
    check("err_sticky", 64'(err), 64'd1);
    do_read(26'h20, "post_oor_rd");

    // Reset during RD_WAIT discards the read.
    raddr = AW'(5); rvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstw_issue_ce", 64'({mem_ce, mem_we}), 64'd2);
    @(posedge clk); #1;
    rst = 1'b1; rvalid = 1'b0;
    #1;
    check("rstw_ctrl", 64'({rready, wready, mem_ce, mem_we, err, busy}), 64'd0);
    check("rstw_data", 64'({rdata, mem_wdata}), 64'd0);
    check("rstw_maddr", 64'(mem_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rr_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rready) rr_cnt++;
    end
    check("rstw_no_rready", 64'(rr_cnt), 64'd0);
    @(posedge clk); #1;
    do_read(AW'(5), "rstw_reread");

    // Back-to-back writes to 0..7 with wvalid held.
    wr_log_a.delete(); wr_log_d.delete();
    for (int i = 0; i < 8; i++) b2b_d[i] = $urandom;
    n = 0; k = 0; busy_err = 0;
    waddr = '0; wdata = b2b_d[0]; wvalid = 1'b1;
    while (n < 8 && k < 60) begin
      @(negedge clk);
      wa = wready;
      if (busy !== (k % 2 == 1)) busy_err++;
      if (wa) check($sformatf("b2b_wready_cyc%0d", n), 64'(k), 64'(2 * n + 1));
      k++;
      @(posedge clk); #1;
      if (wa) begin
        ref_mem[n] = b2b_d[n];
        n++;
        if (n == 8) wvalid = 1'b0;
        else begin waddr = AW'(n); wdata = b2b_d[n]; end
      end
    end
    check("b2b_count", 64'(n), 64'd8);
    check("b2b_busy", 64'(busy_err), 64'd0);
    check("b2b_sram_writes", 64'(wr_log_a.size()), 64'd8);
    for (int i = 0; i < 8 && i < wr_log_a.size(); i++) begin
      check($sformatf("b2b_addr%0d", i), 64'(wr_log_a[i]), 64'(i));
      check($sformatf("b2b_data%0d", i), 64'(wr_log_d[i]), 64'(b2b_d[i]));
    end
    do_read(AW'(7), "b2b_rd7");

    for (int i = 0; i < 3000 && !(g_sweep[0].done && g_sweep[1].done); i++) @(posedge clk);
    check("sweep_done", 64'({g_sweep[0].done, g_sweep[1].done}), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/genie_mem_ctrl.md
# genie_mem_ctrl

Memory-side controller that sits directly downstream of the accelerator's shared data port. It services the accelerator's read and write request channels, which the FC/CV/MP data loaders drive through the top-level mux, against a single-port synchronous SRAM with configurable read latency. It arbitrates reads against writes round-robin. It returns each read word with a one-cycle `rready` strobe and acknowledges each write with a one-cycle `wready` strobe. Out-of-range accesses are flagged and never reach the SRAM.

## Interface
- `AW`, 26, word address width
- `DW`, 32, data width
- `RD_LAT`, 2, SRAM read latency in cycles (legal 1..7)
- `MEM_WORDS`, 1<<20, number of implemented SRAM words; valid addresses are 0..MEM_WORDS-1

Ports:
- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wvalid`  in  1  write request; held with `waddr`/`wdata` stable until `wready`
- `wready`  out  1  one-cycle write acknowledge
- `waddr`  in  AW  write word address
- `wdata`  in  DW  write data
- `rvalid`  in  1  read request; held with `raddr` stable until `rready`
- `rready`  out  1  one-cycle read-data strobe; `rdata` is valid in this cycle only
- `raddr`  in  AW  read word address
- `rdata`  out  DW  read data
- `mem_ce`  out  1  SRAM chip enable
- `mem_we`  out  1  SRAM write enable (meaningful only with `mem_ce`)
- `mem_addr`  out  AW  SRAM address
- `mem_wdata`  out  DW  SRAM write data
- `mem_rdata`  in  DW  SRAM read data; valid RD_LAT cycles after the `mem_ce` read cycle
- `err`  out  1  sticky out-of-range flag
- `busy`  out  1  high in every state other than IDLE

## Operation
- Reset: every output is 0. State goes to IDLE. `last_grant` is set to WRITE, so the first contended grant goes to the read channel.
- Grant rules in IDLE:
  - Only `rvalid` is high: grant READ.
  - Only `wvalid` is high: grant WRITE.
  - Both are high: grant the channel opposite `last_grant`, then update `last_grant`.
  - Neither is high: stay in IDLE.
- Requests are sampled only in IDLE. A request held high during its own ack cycle is never re-accepted.
- Range check on the granted address (`addr >= MEM_WORDS`):
  - Go to state OOR for one cycle and set `err`.
  - Pulse `rready` with `rdata`=0, or pulse `wready`, in the OOR cycle.
  - `mem_ce` stays 0 throughout.
- State sequences:
  - WRITE: IDLE → WR (`mem_ce`=1, `mem_we`=1, `mem_addr`=`waddr`, `mem_wdata`=`wdata`, `wready`=1) → IDLE.
  - READ: IDLE → RD_ISSUE (`mem_ce`=1, `mem_we`=0, `mem_addr`=`raddr`) → RD_WAIT for RD_LAT cycles (latency counter) → RD_ACK (`rready`=1, `rdata` = word captured from `mem_rdata` on the last RD_WAIT cycle) → IDLE.
- `rdata` holds its last value outside RD_ACK/OOR. `mem_addr` and `mem_wdata` also hold their last values.
- `mem_ce` and `mem_we` are high only in the states listed above.
- `err` clears only on `rst`.
- At most one request is in flight at any time. There is no reordering and no write data buffering.

## Timing
- All outputs are registered. Requests are sampled at cycle T (IDLE).
- Write: SRAM write and `wready` both occur in T+1. The next request can be accepted at T+2, giving 2 cycles per write.
- Read: `mem_ce` in T+1, `mem_rdata` sampled in T+1+RD_LAT, `rready` in T+2+RD_LAT.
  - Next acceptance is at T+3+RD_LAT.
  - With RD_LAT=2: `rready` in T+4, 5 cycles per read.
- OOR: ack in T+1, next acceptance at T+2.
- Simultaneous `rvalid` and `wvalid` held continuously: grants alternate R, W, R, W…
- A read to an address written by the preceding granted write returns the new data. This holds because writes complete in the SRAM before any later issue.
- A `valid` deassertion before its ack is a protocol violation; behaviour is undefined.
- `rst` mid-operation clears state and outputs at once:
  - An in-flight read is discarded and never acked.
  - `mem_ce` drops in the same cycle.
  - A pending requester must re-present its request after reset.

## Test plan
- Single write then read, RD_LAT=2: write 0x00000010 ← 0xDEADBEEF; read 0x10.
  - `wready` at T+1, `mem_we`=1 at T+1.
  - `rready` 4 cycles after read acceptance, with `rdata`=0xDEADBEEF.
- Contention: `rvalid` and `wvalid` asserted together from reset and held for four requests each.
  - Grant order is R, W, R, W, R, W, R, W.
  - No ack lands in a cycle where the other channel acks.
- Out-of-range, MEM_WORDS=1024: read at 0x400.
  - `rready` at T+1, `rdata`=0, `err`=1, `mem_ce` never high.
  - A subsequent in-range write still completes; `err` stays 1.
- Latency sweep RD_LAT=1 and RD_LAT=7: back-to-back reads of 0..15 against a preloaded SRAM model (word = addr×3).
  - Read period is 4 and 10 cycles respectively.
  - All 16 data words match.
- Reset in RD_WAIT: assert `rst` one cycle after RD_ISSUE.
  - All outputs are 0 in the same cycle and no `rready` ever appears for that read.
  - After release, a re-presented read completes normally.
- Back-to-back writes: `wvalid` held with address incrementing 0..7 after each `wready`.
  - Exactly one `wready` every 2 cycles and 8 SRAM writes at the correct addresses.
  - `busy` low only in the IDLE cycles between writes.
